// File: rtl/valid_ready_upsizer_pkg.sv
// valid_ready_upsizer_pkg
//   Shared types and helpers for the width up/down-sizer family.
//   upsz_state_t : ACC (collecting beats) / FULL (word held for output)
//   upsz_cnt_w() : width of a beat-count field able to hold 0..k
package valid_ready_upsizer_pkg;

    typedef enum logic {
        ACC  = 1'b0,
        FULL = 1'b1
    } upsz_state_t;

    function automatic int upsz_cnt_w(input int k);
        return $clog2(k + 1);
    endfunction

endpackage

// File: rtl/valid_ready_upsizer_if.sv
// valid_ready_upsizer_if
//   Bundles the narrow input stream (dwn_*) and the wide output stream (up_*)
//   of the upsizer.
//   slave  : the upsizer side (consumes dwn_*, produces up_*)
//   master : the environment side (produces dwn_*, consumes up_*)
//   dwn_data[N], dwn_vld, dwn_last, dwn_rdy : input beat handshake
//   up_data[N*K], up_cnt, up_vld, up_rdy    : output word handshake
interface valid_ready_upsizer_if
    import valid_ready_upsizer_pkg::*;
#(
    parameter int N = 4,
    parameter int K = 4
);
    logic [N-1:0]               dwn_data;
    logic                       dwn_vld;
    logic                       dwn_last;
    logic                       dwn_rdy;
    logic [N*K-1:0]             up_data;
    logic [upsz_cnt_w(K)-1:0]   up_cnt;
    logic                       up_vld;
    logic                       up_rdy;

    modport slave (
        input  dwn_data, dwn_vld, dwn_last, up_rdy,
        output dwn_rdy, up_data, up_cnt, up_vld
    );

    modport master (
        output dwn_data, dwn_vld, dwn_last, up_rdy,
        input  dwn_rdy, up_data, up_cnt, up_vld
    );
endinterface

// File: rtl/valid_ready_upsizer.sv
// valid_ready_upsizer
//   Packs K consecutive N-bit beats into one N*K-bit word. dwn_last closes a
//   partial word early; unwritten slots read as zero and up_cnt gives the
//   number of valid beats (1..K). Sustains one beat per cycle: in FULL a new
//   beat is accepted in the same cycle the held word drains.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : slave modport, dwn_* beats in, up_* words out
//          (beat 0 lands in up_data[N-1:0])
module valid_ready_upsizer
    import valid_ready_upsizer_pkg::*;
#(
    parameter int N = 4,
    parameter int K = 4
)(
    input  logic                    clk,
    input  logic                    rst,
    valid_ready_upsizer_if.slave    bus
);
    localparam int CW = upsz_cnt_w(K);
    localparam int IW = $clog2(K);

    upsz_state_t           state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [K-1:0][N-1:0]   slot_q, slot_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  beat;
    logic                  wacc;

    // Ready is held low while in reset; in FULL it follows the consumer so a
    // beat can slip in on the drain cycle.
    assign bus.dwn_rdy = rst & ((state_q == ACC) | bus.up_rdy);
    assign beat        = bus.dwn_vld & bus.dwn_rdy;
    assign wacc        = (state_q == FULL) & bus.up_rdy;

    assign bus.up_vld  = (state_q == FULL);
    assign bus.up_data = slot_q;
    assign bus.up_cnt  = cnt_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        slot_d  = slot_q;
        cnt_d   = cnt_q;
        case (state_q)
            ACC: begin
                if (beat) begin
                    // Slot 0 starts a fresh word: wipe stale beats so a
                    // partial word comes out zero-padded.
                    if (idx_q == '0)
                        slot_d = '0;
                    slot_d[idx_q] = bus.dwn_data;
                    if (idx_q == IW'(K - 1) || bus.dwn_last) begin
                        state_d = FULL;
                        cnt_d   = CW'(idx_q) + CW'(1);
                        idx_d   = '0;
                    end else begin
                        idx_d   = idx_q + IW'(1);
                    end
                end
            end
            FULL: begin
                if (wacc) begin
                    if (beat) begin
                        slot_d    = '0;
                        slot_d[0] = bus.dwn_data;
                        if (bus.dwn_last) begin
                            // Single-beat word closes immediately.
                            state_d = FULL;
                            cnt_d   = CW'(1);
                            idx_d   = '0;
                        end else begin
                            state_d = ACC;
                            idx_d   = IW'(1);
                        end
                    end else begin
                        state_d = ACC;
                        idx_d   = '0;
                    end
                end
            end
            default: begin
                state_d = ACC;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ACC;
            idx_q   <= '0;
            slot_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            slot_q  <= slot_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
